// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and width bounds for gray_counter.
// Functions work on 32-bit containers; callers zero-extend narrower values
// and truncate the result, which is exact because the upper bits are zero.
package gray_pkg;

  localparam int GRAY_WIDTH_MIN = 2;
  localparam int GRAY_WIDTH_MAX = 32;

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_gray_to_binary.sv
// gray_to_binary: combinational Gray-to-binary converter used on the load path.
// Ports: gray (WIDTH, Gray-coded input), bin (WIDTH, binary result).
// Purely combinational; the result is registered by the parent.
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(32'(gray)));

endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down counter holding binary and Gray counts in separate flops.
// Ports: clk, rst (async active-high), en, up, load, load_gray, din[WIDTH]
//        -> bin_out[WIDTH], gray_out[WIDTH], tc (one-cycle terminal pulse).
// Optional macro GRAY_COUNTER_SAT_EN: saturate at the limits instead of wrapping.
// WIDTH must lie within gray_pkg::GRAY_WIDTH_MIN..GRAY_WIDTH_MAX.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RST_BIN)));
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] bin_q, gray_q;
  logic             tc_q;
  logic [WIDTH-1:0] bin_n, gray_n;
  logic             tc_n;
  logic [WIDTH-1:0] din_as_bin;
  logic             at_limit;

  gray_to_binary #(.WIDTH(WIDTH)) u_g2b (
    .gray (din),
    .bin  (din_as_bin)
  );

  // Limit in the currently requested direction: a step here wraps or saturates.
  assign at_limit = up ? (bin_q == ALL_ONES) : (bin_q == '0);

  always_comb begin
    bin_n  = bin_q;
    gray_n = gray_q;
    tc_n   = 1'b0;
    if (load) begin
      // Load beats enable and never raises tc, even for a terminal value.
      if (load_gray) begin
        bin_n  = din_as_bin;
        gray_n = din;
      end else begin
        bin_n  = din;
        gray_n = WIDTH'(bin2gray(32'(din)));
      end
    end else if (en) begin
      tc_n = at_limit;
`ifdef GRAY_COUNTER_SAT_EN
      if (!at_limit) begin
        bin_n  = up ? bin_q + 1'b1 : bin_q - 1'b1;
        gray_n = WIDTH'(bin2gray(32'(bin_n)));
      end
`else
      bin_n  = up ? bin_q + 1'b1 : bin_q - 1'b1;
      gray_n = WIDTH'(bin2gray(32'(bin_n)));
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_n;
      gray_q <= gray_n;
      tc_q   <= tc_n;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign tc       = tc_q;

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter RESET_VAL, default 0, binary count value applied at reset, masked to WIDTH bits.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port en, input, 1, count enable; one step per cycle while high.
REQ-006 SHALL have port up, input, 1, direction; 1 = increment, 0 = decrement.
REQ-007 SHALL have port load, input, 1, synchronous load strobe.
REQ-008 SHALL have port load_gray, input, 1, 1 = din is Gray-coded, 0 = din is binary.
REQ-009 SHALL have port din, input, WIDTH, load value.
REQ-010 SHALL have port bin_out, output, WIDTH, registered binary count.
REQ-011 SHALL have port gray_out, output, WIDTH, registered Gray count, equal to bin_out ^ (bin_out >> 1).
REQ-012 SHALL have port tc, output, 1, registered one-cycle terminal-event pulse.

Function
REQ-013 SHALL hold bin_out and gray_out in separate flops; gray_out SHALL NOT be decoded combinationally from bin_out.
REQ-014 SHALL update all outputs only on the rising clk edge after the inputs are sampled, one-cycle latency.
REQ-015 SHALL give load priority over en; with load and en high together, the loaded value SHALL win and no step SHALL occur.
REQ-016 With load=1 and load_gray=0, SHALL set bin_out=din and gray_out=din^(din>>1).
REQ-017 With load=1 and load_gray=1, SHALL set gray_out=din and bin_out=Gray-to-binary(din), where bit i is the XOR of din[WIDTH-1:i].
REQ-018 With en=1 and load=0, SHALL step bin_out by +1 (up=1) or -1 (up=0) modulo 2^WIDTH.
REQ-019 With en=0 and load=0, SHALL hold both counts and SHALL drive tc=0.
REQ-020 On each enabled step, gray_out SHALL change in exactly one bit position, including across wrap.
REQ-021 SHALL pulse tc high for one cycle on the edge where the count wraps (all-ones to 0 when up, 0 to all-ones when down).
REQ-022 SHALL drive tc=0 on any load cycle, even when the loaded value is a terminal value.
REQ-023 SHALL allow the direction to change on any cycle without a dead cycle; the step SHALL use the up value sampled on that edge.

Reset
REQ-024 On rst assertion, SHALL immediately, without waiting for clk, drive bin_out=RESET_VAL, gray_out=RESET_VAL^(RESET_VAL>>1) and tc=0.
REQ-025 While rst is high, SHALL ignore en, load and din.
REQ-026 Reset asserted mid-count SHALL abandon the pending step; the first step after rst falls SHALL start from RESET_VAL.

Configuration
REQ-027 SHALL support macro GRAY_COUNTER_SAT_EN.
REQ-028 Without GRAY_COUNTER_SAT_EN, SHALL wrap as in REQ-018 and REQ-021.
REQ-029 With GRAY_COUNTER_SAT_EN, SHALL hold at all-ones (up) or 0 (down) instead of wrapping, and SHALL pulse tc for one cycle on each enabled cycle that requests a step past the limit.
REQ-030 With GRAY_COUNTER_SAT_EN, a step away from the limit SHALL proceed normally.

Structure
REQ-031 SHALL place the Gray helper functions (bin-to-Gray, Gray-to-bin) and the WIDTH bounds constants in shared package gray_pkg.
REQ-032 SHALL instantiate one sub-module, gray_to_binary (parametrised by WIDTH), for the load_gray conversion path.
REQ-033 SHALL contain no latches and no combinational path from any input to any output.

Verification (WIDTH=4, RESET_VAL=0 unless stated)
REQ-034 SHALL test reset then en=1, up=1 for 16 cycles -> gray_out sequence 0000,0001,0011,0010,0110,...,1000,0000; tc high only on the 1111->0000 edge.
REQ-035 SHALL test load=1, load_gray=1, din=1010 -> bin_out=1100, gray_out=1010; then en=1, up=0 -> bin_out=1011, gray_out=1110.
REQ-036 SHALL test load=1 and en=1 together with din=0111, load_gray=0 -> bin_out=0111, gray_out=0100, tc=0.
REQ-037 SHALL test bin_out=0000, en=1, up=0 -> bin_out=1111, gray_out=1000, tc pulse; with GRAY_COUNTER_SAT_EN -> bin_out holds 0000, tc pulses each cycle.
REQ-038 SHALL test rst asserted between clock edges at count 0101 -> outputs 0000/0000 before the next edge; with RESET_VAL=9 -> bin_out=1001, gray_out=1101.
REQ-039 SHALL check, on every enabled step in all tests, that the Hamming distance between consecutive gray_out values is exactly 1.
